// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage 16-bit core: operand-forward selects,
// load-use stall/bubble, taken-branch squash, HALT drain sequencing and saturating perf counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_RUN    | normal issue; ID may advance into EX
// S_DRAIN  | HALT has left ID; IF/ID held while it walks down to WB
// S_HALTED | HALT retired; front end held until rst
module hazard_fwd_ctrl #(
   parameter int REGW         = 3,
   parameter int CNTW         = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [REGW-1:0] id_srcA,
   input  logic            id_srcA_valid,
   input  logic [REGW-1:0] id_srcB,
   input  logic            id_srcB_valid,
   input  logic [REGW-1:0] id_rd,
   input  logic            id_rd_valid,
   input  logic            id_is_load,
   input  logic            id_is_halt,
   input  logic            ex_branch_taken,
   output logic [1:0]      forwardA,
   output logic [1:0]      forwardB,
   output logic            stall_if_id,
   output logic            bubble_id_ex,
   output logic            flush_if_id,
   output logic            halt_done,
   output logic [CNTW-1:0] stall_count,
   output logic [CNTW-1:0] flush_count
);

   localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_EX  = 2'b10;

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_HALTED
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [DCW-1:0]   drain_cnt;
   logic [DCW-1:0]   drain_cnt_nxt;

   // WB retires through a write-through regfile, so only EX and MEM entries are consulted.
   logic             ex_v;
   logic             ex_ld;
   logic [REGW-1:0]  ex_rd;
   logic             mem_v;
   logic [REGW-1:0]  mem_rd;

   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;
   logic [1:0]       fwd_a_nxt;
   logic [1:0]       fwd_b_nxt;

   logic             in_run;
   logic             flush;
   logic             hit_a;
   logic             hit_b;
   logic             load_use;
   logic             stall;
   logic             advance;

   function automatic logic [1:0] fwd_sel(
      input logic            src_valid,
      input logic [REGW-1:0] src,
      input logic            e_v,
      input logic [REGW-1:0] e_rd,
      input logic            e_ld,
      input logic            m_v,
      input logic [REGW-1:0] m_rd
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (src_valid) begin
         if (e_v && (e_rd == src) && !e_ld) begin
            sel = FWD_EX;
         end else if (m_v && (m_rd == src)) begin
            sel = FWD_MEM;
         end
      end
      return sel;
   endfunction

   always_comb begin
      in_run   = (state == S_RUN);
      flush    = ex_branch_taken;
      hit_a    = id_srcA_valid && (id_srcA == ex_rd);
      hit_b    = id_srcB_valid && (id_srcB == ex_rd);
      load_use = id_valid && in_run && ex_v && ex_ld && (hit_a || hit_b);
      // A redirect releases the front end, overriding both load-use and drain holds.
      stall    = (state == S_HALTED) || (!flush && (load_use || (state == S_DRAIN)));
      advance  = id_valid && in_run && !stall && !flush;
   end

   always_comb begin
      fwd_a_nxt = FWD_RF;
      fwd_b_nxt = FWD_RF;
      if (advance) begin
         fwd_a_nxt = fwd_sel(id_srcA_valid, id_srcA, ex_v, ex_rd, ex_ld, mem_v, mem_rd);
         fwd_b_nxt = fwd_sel(id_srcB_valid, id_srcB, ex_v, ex_rd, ex_ld, mem_v, mem_rd);
      end
   end

   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      case (state)
         S_RUN: begin
            if (advance && id_is_halt) begin
               state_nxt     = S_DRAIN;
               drain_cnt_nxt = DCW'(DRAIN_CYCLES - 1);
            end
         end
         S_DRAIN: begin
            // A taken branch ahead of the HALT means the HALT was on the wrong path.
            if (flush) begin
               state_nxt = S_RUN;
            end else if (drain_cnt == '0) begin
               state_nxt = S_HALTED;
            end else begin
               drain_cnt_nxt = drain_cnt - DCW'(1);
            end
         end
         S_HALTED: begin
            state_nxt = S_HALTED;
         end
         default: begin
            state_nxt = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_RUN;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_v   <= 1'b0;
         ex_ld  <= 1'b0;
         ex_rd  <= '0;
         mem_v  <= 1'b0;
         mem_rd <= '0;
         fwd_a  <= FWD_RF;
         fwd_b  <= FWD_RF;
      end else begin
         mem_v  <= ex_v;
         mem_rd <= ex_rd;
         if (advance) begin
            ex_v  <= id_rd_valid;
            ex_ld <= id_is_load;
            ex_rd <= id_rd;
         end else begin
            ex_v  <= 1'b0;
            ex_ld <= 1'b0;
            ex_rd <= '0;
         end
         fwd_a <= fwd_a_nxt;
         fwd_b <= fwd_b_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (load_use && !flush && (stall_count != '1)) begin
            stall_count <= stall_count + CNTW'(1);
         end
         if (flush && (flush_count != '1)) begin
            flush_count <= flush_count + CNTW'(1);
         end
      end
   end

   assign forwardA     = fwd_a;
   assign forwardB     = fwd_b;
   assign stall_if_id  = stall;
   assign bubble_id_ex = load_use || flush;
   assign flush_if_id  = flush;
   assign halt_done    = (state == S_HALTED);

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: each driven cycle queues its hand-derived expected
// outputs, and the negedge monitor pops and compares them.
module tb_hazard_fwd_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [2:0]  id_srcA;
   logic        id_srcA_valid;
   logic [2:0]  id_srcB;
   logic        id_srcB_valid;
   logic [2:0]  id_rd;
   logic        id_rd_valid;
   logic        id_is_load;
   logic        id_is_halt;
   logic        ex_branch_taken;
   logic [1:0]  forwardA;
   logic [1:0]  forwardB;
   logic        stall_if_id;
   logic        bubble_id_ex;
   logic        flush_if_id;
   logic        halt_done;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   hazard_fwd_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .id_valid        (id_valid),
      .id_srcA         (id_srcA),
      .id_srcA_valid   (id_srcA_valid),
      .id_srcB         (id_srcB),
      .id_srcB_valid   (id_srcB_valid),
      .id_rd           (id_rd),
      .id_rd_valid     (id_rd_valid),
      .id_is_load      (id_is_load),
      .id_is_halt      (id_is_halt),
      .ex_branch_taken (ex_branch_taken),
      .forwardA        (forwardA),
      .forwardB        (forwardB),
      .stall_if_id     (stall_if_id),
      .bubble_id_ex    (bubble_id_ex),
      .flush_if_id     (flush_if_id),
      .halt_done       (halt_done),
      .stall_count     (stall_count),
      .flush_count     (flush_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       v;
      logic [2:0] a;
      logic       av;
      logic [2:0] b;
      logic       bv;
      logic [2:0] rd;
      logic       rdv;
      logic       ld;
      logic       halt;
   } ins_t;

   typedef struct packed {
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        stall;
      logic        bub;
      logic        flush;
      logic        halt;
      logic        cc;
      logic [15:0] sc;
      logic [15:0] fc;
   } exp_t;

   localparam ins_t NOP = '0;
   localparam exp_t Z   = '0;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_cmp = 0;
   int    n_err = 0;
   int    cyc   = 0;
   logic  done  = 1'b0;

   function automatic ins_t alu(input logic [2:0] rd, input logic [2:0] a, input logic [2:0] b);
      ins_t i;
      i = '0; i.v = 1'b1; i.rd = rd; i.rdv = 1'b1;
      i.a = a; i.av = 1'b1; i.b = b; i.bv = 1'b1;
      return i;
   endfunction

   function automatic ins_t ld(input logic [2:0] rd, input logic [2:0] a);
      ins_t i;
      i = '0; i.v = 1'b1; i.rd = rd; i.rdv = 1'b1; i.ld = 1'b1;
      i.a = a; i.av = 1'b1;
      return i;
   endfunction

   function automatic ins_t imm(input logic [2:0] rd);
      ins_t i;
      i = '0; i.v = 1'b1; i.rd = rd; i.rdv = 1'b1;
      return i;
   endfunction

   function automatic ins_t hlt();
      ins_t i;
      i = '0; i.v = 1'b1; i.halt = 1'b1;
      return i;
   endfunction

   function automatic exp_t ex(input logic st, input logic bub, input logic fl, input logic hd,
                               input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      e = '0; e.stall = st; e.bub = bub; e.flush = fl; e.halt = hd; e.fa = fa; e.fb = fb;
      return e;
   endfunction

   function automatic exp_t with_cnt(input exp_t e, input logic [15:0] sc, input logic [15:0] fc);
      exp_t r;
      r = e; r.cc = 1'b1; r.sc = sc; r.fc = fc;
      return r;
   endfunction

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   task automatic apply(input ins_t i, input logic br);
      id_valid        = i.v;
      id_srcA         = i.a;
      id_srcA_valid   = i.av;
      id_srcB         = i.b;
      id_srcB_valid   = i.bv;
      id_rd           = i.rd;
      id_rd_valid     = i.rdv;
      id_is_load      = i.ld;
      id_is_halt      = i.halt;
      ex_branch_taken = br;
   endtask

   task automatic expect_now(input exp_t e, input string tag);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic drive(input ins_t i, input logic br, input exp_t e, input string tag);
      @(posedge clk);
      #1;
      apply(i, br);
      expect_now(e, tag);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(NOP, 1'b0, Z, "idle");
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   always @(negedge clk) begin
      exp_t  e;
      string t;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk_val({t, ".stall"},    32'(stall_if_id),  32'(e.stall));
         chk_val({t, ".bubble"},   32'(bubble_id_ex), 32'(e.bub));
         chk_val({t, ".flush"},    32'(flush_if_id),  32'(e.flush));
         chk_val({t, ".halt"},     32'(halt_done),    32'(e.halt));
         chk_val({t, ".forwardA"}, 32'(forwardA),     32'(e.fa));
         chk_val({t, ".forwardB"}, 32'(forwardB),     32'(e.fb));
         if (e.cc) begin
            chk_val({t, ".stall_count"}, 32'(stall_count), 32'(e.sc));
            chk_val({t, ".flush_count"}, 32'(flush_count), 32'(e.fc));
         end
      end else if (done) begin
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
         $finish;
      end
      if (cyc > 5000) begin
         chk_val("watchdog", 32'(cyc), 32'(0));
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
         $finish;
      end
   end

   initial begin
      ins_t o2;
      rst = 1'b1;
      apply(NOP, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      drive(NOP, 1'b0, with_cnt(Z, 16'd0, 16'd0), "reset");

      // load-use: one stall/bubble, then MEM forward to operand A
      drive(ld(3'd1, 3'd4),       1'b0, Z, "lu_ld");
      drive(alu(3'd2, 3'd1, 3'd3), 1'b0, ex(1, 1, 0, 0, 2'b00, 2'b00), "lu_stall");
      drive(alu(3'd2, 3'd1, 3'd3), 1'b0, Z, "lu_adv");
      drive(NOP, 1'b0, with_cnt(ex(0, 0, 0, 0, 2'b01, 2'b00), 16'd1, 16'd0), "lu_fwdA");
      idle(3);

      // back-to-back ALU: EX forward; with a gap: MEM forward
      drive(alu(3'd1, 3'd2, 3'd3), 1'b0, Z, "fx_add");
      drive(alu(3'd4, 3'd5, 3'd1), 1'b0, Z, "fx_sub");
      drive(NOP, 1'b0, ex(0, 0, 0, 0, 2'b00, 2'b10), "fx_fwdB10");
      idle(3);
      drive(alu(3'd1, 3'd2, 3'd3), 1'b0, Z, "fm_add");
      drive(imm(3'd7),             1'b0, Z, "fm_mid");
      drive(alu(3'd4, 3'd5, 3'd1), 1'b0, Z, "fm_sub");
      drive(NOP, 1'b0, ex(0, 0, 0, 0, 2'b00, 2'b01), "fm_fwdB01");
      idle(3);

      // youngest producer wins; unset srcB_valid suppresses forwarding
      o2 = alu(3'd6, 3'd1, 3'd1);
      o2.bv = 1'b0;
      drive(alu(3'd1, 3'd2, 3'd3), 1'b0, Z, "yp_add1");
      drive(alu(3'd1, 3'd2, 3'd3), 1'b0, Z, "yp_add2");
      drive(alu(3'd6, 3'd1, 3'd1), 1'b0, Z, "yp_or");
      drive(o2, 1'b0, ex(0, 0, 0, 0, 2'b10, 2'b10), "yp_both10");
      drive(NOP, 1'b0, ex(0, 0, 0, 0, 2'b01, 2'b00), "yp_nosrcB");
      idle(3);

      // taken branch overrides a pending load-use stall
      do_reset();
      drive(NOP, 1'b0, with_cnt(Z, 16'd0, 16'd0), "rst1_cnt");
      drive(ld(3'd1, 3'd4),        1'b0, Z, "fl_ld");
      drive(alu(3'd2, 3'd1, 3'd3), 1'b1, ex(0, 1, 1, 0, 2'b00, 2'b00), "fl_over");
      drive(NOP, 1'b0, with_cnt(Z, 16'd0, 16'd1), "fl_cnt");
      idle(3);

      // HALT: three drain cycles, then held halted until rst
      drive(hlt(), 1'b0, Z, "h_adv");
      drive(NOP, 1'b0, ex(1, 0, 0, 0, 2'b00, 2'b00), "h_drain1");
      drive(NOP, 1'b0, ex(1, 0, 0, 0, 2'b00, 2'b00), "h_drain2");
      drive(NOP, 1'b0, ex(1, 0, 0, 0, 2'b00, 2'b00), "h_drain3");
      drive(NOP, 1'b0, ex(1, 0, 0, 1, 2'b00, 2'b00), "h_halted");
      drive(alu(3'd3, 3'd1, 3'd2), 1'b0, ex(1, 0, 0, 1, 2'b00, 2'b00), "h_hold1");
      drive(NOP, 1'b0, ex(1, 0, 0, 1, 2'b00, 2'b00), "h_hold2");
      do_reset();
      drive(NOP, 1'b0, with_cnt(Z, 16'd0, 16'd0), "rst_from_halt");

      // branch during drain returns to RUN
      drive(hlt(), 1'b0, Z, "hb_adv");
      drive(NOP, 1'b0, ex(1, 0, 0, 0, 2'b00, 2'b00), "hb_drain1");
      drive(NOP, 1'b1, ex(0, 1, 1, 0, 2'b00, 2'b00), "hb_flush");
      drive(NOP, 1'b0, with_cnt(Z, 16'd0, 16'd1), "hb_run");
      drive(NOP, 1'b0, Z, "hb_run2");
      drive(NOP, 1'b0, Z, "hb_run3");

      // rst asserted in the middle of a load-use stall
      drive(ld(3'd1, 3'd4),        1'b0, Z, "rs_ld");
      drive(alu(3'd2, 3'd1, 3'd3), 1'b0, ex(1, 1, 0, 0, 2'b00, 2'b00), "rs_stall");
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      expect_now(with_cnt(Z, 16'd0, 16'd0), "rs_after");
      idle(2);

      // rst asserted during drain, then normal RUN behaviour resumes
      drive(hlt(), 1'b0, Z, "rd_adv");
      drive(NOP, 1'b0, ex(1, 0, 0, 0, 2'b00, 2'b00), "rd_drain1");
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      apply(NOP, 1'b0);
      expect_now(with_cnt(Z, 16'd0, 16'd0), "rd_after");
      drive(NOP, 1'b0, Z, "rd_run1");
      drive(NOP, 1'b0, Z, "rd_run2");
      drive(ld(3'd3, 3'd4),        1'b0, Z, "rd_ld");
      drive(alu(3'd5, 3'd3, 3'd3), 1'b0, ex(1, 1, 0, 0, 2'b00, 2'b00), "rd_lu");
      drive(alu(3'd5, 3'd3, 3'd3), 1'b0, Z, "rd_adv2");
      drive(NOP, 1'b0, with_cnt(ex(0, 0, 0, 0, 2'b01, 2'b01), 16'd1, 16'd0), "rd_fwd");

      done = 1'b1;
   end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Pipeline hazard controller for the 5-stage 16-bit core.
- Tracks destination registers in flight through EX/MEM/WB in an internal scoreboard.
- Drives the execute stage's 2-bit forwardA/forwardB selects, detects load-use hazards (stall plus bubble), and squashes younger instructions on a taken branch.
- Sequences HALT drain to a halted state; keeps saturating stall/flush performance counters.

Parameters:
REGW, 3, register-address width
CNTW, 16, performance counter width
DRAIN_CYCLES, 3, cycles for a HALT leaving ID to reach WB

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_srcA  in  REGW  operand-A source register
id_srcA_valid  in  1  operand A read from regfile
id_srcB  in  REGW  operand-B source register
id_srcB_valid  in  1  operand B read from regfile
id_rd  in  REGW  destination register
id_rd_valid  in  1  instruction writes rd
id_is_load  in  1  instruction is LD
id_is_halt  in  1  instruction is HALT
ex_branch_taken  in  1  branch/jump in EX redirects PC
forwardA  out  2  EX operand-A select: 00 regfile, 01 MEM/WB data, 10 EX/MEM ALU result, 11 never driven
forwardB  out  2  EX operand-B select, same encoding
stall_if_id  out  1  hold PC and IF/ID
bubble_id_ex  out  1  load NOP into ID/EX
flush_if_id  out  1  squash IF/ID
halt_done  out  1  HALT retired
stall_count  out  CNTW  load-use stall cycles, saturating
flush_count  out  CNTW  taken-branch flushes, saturating

Behaviour:
- Scoreboard: three slots EX, MEM, WB, each {v, rd, ld}. Every cycle: WB<=MEM, MEM<=EX.
  - EX <= ID entry when ID advances (id_valid & ~stall & ~flush & state==RUN); otherwise invalid. A bubble is an invalid entry.
  - Entry v = id_valid & id_rd_valid.
- Load-use (combinational): id_valid & state==RUN & EX.v & EX.ld & ((id_srcA_valid & id_srcA==EX.rd) | (id_srcB_valid & id_srcB==EX.rd)).
  - Raises stall_if_id=1 and bubble_id_ex=1 for exactly that cycle.
  - The next cycle the producer sits in MEM and the instruction advances.
- Forward selects are computed in ID and registered, so they are valid in the cycle the instruction occupies EX. Per source S, only when its valid bit is set:
  - EX.v & EX.rd==S & ~EX.ld -> 10.
  - Else MEM.v & MEM.rd==S -> 01 (covers load results).
  - Else 00.
  - EX beats MEM when both match.
  - Registered value is 00 whenever ID does not advance.
  - Register file is write-through, so WB-slot producers need no forwarding.
- Flush: ex_branch_taken -> flush_if_id=1 and bubble_id_ex=1 the same cycle; EX slot <= invalid.
  - Flush overrides load-use stall: stall_if_id=0 and stall_count does not increment.
  - flush_count increments.
- States:
  - RUN: if id_valid & id_is_halt & ID advances -> DRAIN, counter = DRAIN_CYCLES-1.
  - DRAIN: stall_if_id=1, no new entries enter EX. If ex_branch_taken, the HALT was younger than the branch, so return to RUN (flush as above). Otherwise decrement; at 0 -> HALTED.
  - HALTED: halt_done=1, stall_if_id=1. Exit only via rst.
- Counters: increment by 1 per qualifying cycle; hold at all-ones.
- Reset: scoreboard invalid, state RUN, all outputs 0, counters 0. Reset has priority over every input, including mid-stall and mid-drain.

Test Plan:
- LD R1 then ADD R2,R1,R3 back-to-back -> one cycle of stall_if_id=bubble_id_ex=1; ADD in EX with forwardA=01; stall_count=1.
- ADD R1 then SUB R4,R5,R1 -> no stall; SUB in EX with forwardB=10. With one unrelated instruction between them -> forwardB=01.
- ADD R1; ADD R1; OR R6,R1,R1 -> both selects 10 (youngest producer wins). Unset srcB_valid -> forwardB=00.
- Taken branch in EX while LD-dependent pair sits in IF/ID -> flush_if_id=1, bubble_id_ex=1, stall_if_id=0; flush_count=1, stall_count=0.
- HALT advances -> 3 DRAIN cycles, then halt_done=1 held until rst. Branch taken during DRAIN -> back to RUN, halt_done stays 0.
- rst asserted during a load-use stall and during DRAIN -> next cycle all outputs 0, state RUN, counters 0.
